// File: rtl/s1_fetch_unit.sv
// Stage-1 fetch unit of the 3-stage RV32I core.
// Owns the program counter, drives the synchronous-read BIOS/IMEM address
// ports from pc_next, selects the returning word for stage 2 and keeps the
// cycle / fetch counters read through the CSR/MMIO path.
module s1_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_sel,
  input  logic [31:0] alu_target,
  input  logic [31:0] jal_target,
  input  logic        stall,
  input  logic        kill_s2,
  input  logic        cnt_clr,
  input  logic [31:0] bios_dout,
  input  logic [31:0] imem_dout,
  output logic [11:0] bios_addr,
  output logic [13:0] imem_addr,
  output logic [31:0] pc_s2,
  output logic [31:0] instruction_s2,
  output logic        valid_s2,
  output logic [31:0] cycle_cnt,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    SEL_SEQ = 2'd0,
    SEL_ALU = 2'd1,
    SEL_JAL = 2'd2,
    SEL_RST = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_PC_M4 = RESET_PC - 32'd4;

  pc_sel_e     sel;
  logic [31:0] pc_f;
  logic [31:0] pc_next;
  logic        valid_f;
  logic        valid_next;
  logic [31:0] fetch_word;
  logic        hold;

  assign sel  = pc_sel_e'(pc_sel);
  // A stall only freezes fetch when no redirect is requested.
  assign hold = stall && (sel == SEL_SEQ);

  // Next-PC select: redirects first, then stall hold, then sequential.
  always_comb begin
    pc_next = pc_f + 32'd4;
    unique case (sel)
      SEL_ALU: pc_next = {alu_target[31:2], 2'b00};
      SEL_JAL: pc_next = {jal_target[31:2], 2'b00};
      SEL_RST: pc_next = RESET_PC;
      default: pc_next = hold ? pc_f : pc_f + 32'd4;
    endcase
  end

  // Next fetch-valid: bubble after a reset-vector jump, held while stalled.
  always_comb begin
    valid_next = 1'b1;
    if (sel == SEL_RST) begin
      valid_next = 1'b0;
    end else if (hold) begin
      valid_next = valid_f;
    end
  end

  // Memories are addressed with pc_next so their data lines up with pc_f.
  assign bios_addr = pc_next[13:2];
  assign imem_addr = pc_next[15:2];

  // Source memory is chosen from the registered PC, matching the read latency.
  always_comb begin
    fetch_word = pc_f[30] ? bios_dout : imem_dout;
  end

  assign pc_s2          = pc_f;
  assign valid_s2       = valid_f & ~kill_s2;
  assign instruction_s2 = valid_s2 ? fetch_word : NOP;

  // PC and fetch-valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f    <= RESET_PC_M4;
      valid_f <= 1'b0;
    end else begin
      pc_f    <= pc_next;
      valid_f <= valid_next;
    end
  end

  // Free-running cycle counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
    end else if (cnt_clr) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  // Counts instructions actually handed to stage 3; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (cnt_clr) begin
      fetch_cnt <= '0;
    end else if (valid_s2 && !stall) begin
      fetch_cnt <= fetch_cnt + 32'd1;
    end
  end

endmodule

// File: doc/s1_fetch_unit.md
# s1_fetch_unit

Stage-1 fetch unit of the 3-stage RV32I core. It owns the program counter and drives the synchronous-read BIOS and IMEM address ports. It consumes `pc_sel` and the redirect targets produced by the stage-3 control, and presents the stage-2 instruction, its PC and its valid bit to decode. It also keeps the cycle and fetch counters exposed through the CSR/MMIO path.

## Interface
- `RESET_PC`, default `32'h4000_0000`: first instruction address after reset (BIOS base).
- `NOP`, default `32'h0000_0013`: bubble instruction (`addi x0,x0,0`).

- `clk`  in  1  core clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `pc_sel`  in  2  next-PC select: 0 sequential, 1 `alu_target` (taken branch / jalr), 2 `jal_target`, 3 reset vector.
- `alu_target`  in  32  branch/jalr target from the ALU.
- `jal_target`  in  32  jal target from stage-2 decode.
- `stall`  in  1  hold PC and the stage-2 instruction.
- `kill_s2`  in  1  squash the instruction currently in stage 2 (taken branch resolved in stage 3).
- `cnt_clr`  in  1  synchronous clear of both counters.
- `bios_dout`  in  32  BIOS read data; 1-cycle latency.
- `imem_dout`  in  32  IMEM read data; 1-cycle latency.
- `bios_addr`  out  12  BIOS word address = `pc_next[13:2]`.
- `imem_addr`  out  14  IMEM word address = `pc_next[15:2]`.
- `pc_s2`  out  32  PC of the stage-2 instruction (= `pc_f`).
- `instruction_s2`  out  32  stage-2 instruction, or `NOP` when not valid.
- `valid_s2`  out  1  stage-2 instruction is real.
- `cycle_cnt`  out  32  cycles since reset or last clear.
- `fetch_cnt`  out  32  valid instructions passed to stage 3.

## Operation
- **State:**
  - `pc_f` (32): address of the word emerging from memory this cycle.
  - `valid_f` (1).
  - `cycle_cnt` (32) and `fetch_cnt` (32).
- **Reset values (while `rst`):** `pc_f = RESET_PC-4`, `valid_f = 0`, both counters 0. Consequently `pc_s2 = RESET_PC-4`, `valid_s2 = 0`, `instruction_s2 = NOP`.
- **`pc_next` (combinational), priority order:**
  1. `pc_sel==1`: `{alu_target[31:2],2'b00}`.
  2. `pc_sel==2`: `{jal_target[31:2],2'b00}`.
  3. `pc_sel==3`: `RESET_PC`.
  4. `pc_sel==0` and `stall`: `pc_f`.
  5. Otherwise: `pc_f+4` (modulo 2^32).
- **Redirect beats stall:** a redirect (`pc_sel` 1/2/3) is taken even while `stall=1`.
- **Addresses:** both memory address ports are driven from `pc_next` every cycle, so data for `pc_f` appears one cycle later. While stalled, the same word is re-read and stays stable.
- **Memory select:** source is chosen by the registered `pc_f[30]`: 1 selects `bios_dout`, 0 selects `imem_dout`.
- **Stage-2 outputs:**
  - `valid_s2 = valid_f & ~kill_s2`.
  - `instruction_s2 = valid_s2 ? selected dout : NOP`.
- **`pc_f` update:** `pc_f <= pc_next` every cycle.
- **`valid_f` update:** `valid_f <= 1` every cycle after reset release, except:
  - it holds when `stall & pc_sel==0`;
  - it is forced to 0 the cycle after `pc_sel==3`.
- **`cycle_cnt`:** increments by 1 each cycle; wraps `FFFF_FFFF` to 0.
- **`fetch_cnt`:** increments when `valid_s2 & ~stall`; wraps the same way.
- **`cnt_clr`:** has priority over increment; the counter reads 0 on the following cycle.
- **`kill_s2`:** squashes combinationally only and does not alter `pc_f`. The control asserts it together with `pc_sel==1` for a taken branch.

## Timing
- Fetch latency is 1 cycle from `pc_next` to `instruction_s2`.
- Branch penalty is 1 squashed instruction plus the stage-3 resolution slot. Jal, resolved in stage 2, costs 0 squashes in this block.
- **First fetch after reset release:**
  - Edge 1: `pc_f = RESET_PC`, `valid_f = 1`.
  - `instruction_s2 = mem[RESET_PC]` in that same cycle.
- **Reset mid-operation:** all state returns to reset values immediately; no further memory data is used until release.
- **Simultaneous `kill_s2` and `stall`:** the output is a bubble and `fetch_cnt` does not increment.

## Test plan
- **Reset release:** hold `rst` for 3 cycles, release with `pc_sel=0`, BIOS returns word = address. Expect `valid_s2=0` during reset; on the first post-release cycle `pc_s2=4000_0000`, `instruction_s2=4000_0000`, `valid_s2=1`. Then `4000_0004`, `4000_0008` on consecutive cycles.
- **IMEM select:** redirect `pc_sel=1`, `alu_target=1000_0102`. Expect `imem_addr=0x040` (low bits masked) the same cycle; next cycle `pc_s2=1000_0100` with `instruction_s2=imem_dout`.
- **Stall:** assert `stall` for 2 cycles at `pc_s2=4000_0010`. Expect `pc_s2`, `instruction_s2` and `bios_addr` held and `fetch_cnt` frozen; resume at `4000_0014`.
- **Branch kill:** with `kill_s2=1` and `pc_sel=1`, `alu_target=4000_0100`. Expect that cycle `instruction_s2=0000_0013` and `valid_s2=0`; next cycle `pc_s2=4000_0100`, valid.
- **Redirect during stall:** `stall=1`, `pc_sel=2`, `jal_target=4000_0200`. Expect `pc_s2=4000_0200` on the next cycle (redirect wins).
- **Counters:** force `cycle_cnt` to `FFFF_FFFF`; expect wrap to 0 on the next cycle. Pulse `cnt_clr`; expect both counters to read 0 the following cycle, then increment.
